// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer. Takes a WIDTH-bit word over a valid/ready
// handshake and emits it as WIDTH/LANES beats of LANES bits, MSB-first or
// LSB-first as chosen per word, with downstream backpressure and a last-beat flag.
module piso_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_lsb_first,
    output logic [LANES-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             busy
);

    localparam int unsigned BEATS = WIDTH / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BEATS - 1);

    // A lane count that does not divide the word would leave a partial final beat.
    generate
        if ((WIDTH < 2) || (LANES < 1) || ((WIDTH % LANES) != 0)) begin : g_bad_params
            $fatal(1, "piso_serializer: WIDTH must be >= 2 and a multiple of LANES >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_d;
    logic             r_lsb_first;
    logic             w_lsb_first_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    logic             w_valid;
    logic             w_last;
    logic             w_accept;
    logic             w_advance;
    logic             w_finish;
    logic [LANES-1:0] w_edge_beat;

    // Handshake decode shared by the next-state logic and the outputs.
    always_comb begin
        w_valid   = (r_state == StShift);
        w_last    = w_valid & (r_cnt == '0);
        s_ready   = ~w_valid | (dout_ready & w_last);
        w_accept  = s_valid & s_ready;
        w_advance = w_valid & dout_ready & ~w_last;
        w_finish  = w_valid & dout_ready & w_last;
    end

    // Next state: accepting wins over finishing so back-to-back words have no bubble.
    always_comb begin
        w_state_d     = r_state;
        w_shift_d     = r_shift;
        w_lsb_first_d = r_lsb_first;
        w_cnt_d       = r_cnt;
        if (w_accept) begin
            w_state_d     = StShift;
            w_shift_d     = s_data;
            w_lsb_first_d = s_lsb_first;
            w_cnt_d       = CNT_LOAD;
        end else if (w_advance) begin
            // Zero fill keeps the register clean once the word drains.
            if (r_lsb_first) begin
                w_shift_d = r_shift >> LANES;
            end else begin
                w_shift_d = r_shift << LANES;
            end
            w_cnt_d = r_cnt - CNT_W'(1);
        end else if (w_finish) begin
            w_state_d = StIdle;
            w_shift_d = '0;
            w_cnt_d   = '0;
        end
    end

    // State register with asynchronous reset; a reset mid-word drops the word entirely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_lsb_first <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_shift     <= w_shift_d;
            r_lsb_first <= w_lsb_first_d;
            r_cnt       <= w_cnt_d;
        end
    end

    // Beats come straight off the leading edge of the shift register.
    always_comb begin
        if (r_lsb_first) begin
            w_edge_beat = r_shift[LANES-1:0];
        end else begin
            w_edge_beat = r_shift[WIDTH-1 -: LANES];
        end
        dout       = w_valid ? w_edge_beat : '0;
        dout_valid = w_valid;
        dout_last  = w_last;
        busy       = w_valid;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one 8x1 instance and one 8x2 instance on
// a shared clock and reset, with hand-computed beat sequences.
module tb_piso_serializer;

    logic clk;
    logic reset;

    logic       s_valid1, s_ready1, s_lsb1, dout1, dv1, dready1, dl1, busy1;
    logic [7:0] s_data1;
    logic       s_valid2, s_ready2, s_lsb2, dv2, dready2, dl2, busy2;
    logic [7:0] s_data2;
    logic [1:0] dout2;

    int n_checks;
    int n_errors;

    logic [7:0] exp_word;
    logic [7:0] exp_lanes;

    piso_serializer #(.WIDTH(8), .LANES(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid1),
        .s_ready    (s_ready1),
        .s_data     (s_data1),
        .s_lsb_first(s_lsb1),
        .dout       (dout1),
        .dout_valid (dv1),
        .dout_ready (dready1),
        .dout_last  (dl1),
        .busy       (busy1)
    );

    piso_serializer #(.WIDTH(8), .LANES(2)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid2),
        .s_ready    (s_ready2),
        .s_data     (s_data2),
        .s_lsb_first(s_lsb2),
        .dout       (dout2),
        .dout_valid (dv2),
        .dout_ready (dready2),
        .dout_last  (dl2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land mid low-phase, away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        s_valid1  = 1'b0;
        s_data1   = 8'h00;
        s_lsb1    = 1'b0;
        dready1   = 1'b1;
        s_valid2  = 1'b0;
        s_data2   = 8'h00;
        s_lsb2    = 1'b0;
        dready2   = 1'b1;

        // Reset then idle.
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("rst_dout", {7'd0, dout1}, 8'd0);
        chk("rst_dv", {7'd0, dv1}, 8'd0);
        chk("rst_last", {7'd0, dl1}, 8'd0);
        chk("rst_busy", {7'd0, busy1}, 8'd0);
        chk("rst_ready", {7'd0, s_ready1}, 8'd1);
        chk("rst_dv2", {7'd0, dv2}, 8'd0);
        chk("rst_ready2", {7'd0, s_ready2}, 8'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_dv", {7'd0, dv1}, 8'd0);
            chk("idle_dout", {7'd0, dout1}, 8'd0);
        end

        // MSB-first 0x1E on 8x1.
        s_valid1 = 1'b1;
        s_data1  = 8'h1E;
        s_lsb1   = 1'b0;
        #1;
        chk("msb_acc_ready", {7'd0, s_ready1}, 8'd1);
        step();
        s_valid1 = 1'b0;
        s_data1  = 8'h00;
        s_lsb1   = 1'b1;
        exp_word = 8'b0001_1110;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("msb_dout", {7'd0, dout1}, {7'd0, exp_word[7-k]});
            chk("msb_dv", {7'd0, dv1}, 8'd1);
            chk("msb_last", {7'd0, dl1}, (k == 7) ? 8'd1 : 8'd0);
            chk("msb_sready", {7'd0, s_ready1}, (k == 7) ? 8'd1 : 8'd0);
            step();
        end
        chk("msb_end_dv", {7'd0, dv1}, 8'd0);
        chk("msb_end_dout", {7'd0, dout1}, 8'd0);
        chk("msb_end_last", {7'd0, dl1}, 8'd0);

        // LSB-first 0x1E followed back-to-back by 0xFF.
        s_valid1 = 1'b1;
        s_data1  = 8'h1E;
        s_lsb1   = 1'b1;
        step();
        s_data1  = 8'hFF;
        s_lsb1   = 1'b0;
        #1;
        exp_word = 8'b0001_1110;
        for (int k = 0; k < 8; k++) begin
            chk("lsb_dout", {7'd0, dout1}, {7'd0, exp_word[k]});
            chk("lsb_last", {7'd0, dl1}, (k == 7) ? 8'd1 : 8'd0);
            chk("lsb_dv", {7'd0, dv1}, 8'd1);
            step();
            if (k == 7) begin
                s_valid1 = 1'b0;
                #1;
            end
        end
        for (int k = 0; k < 8; k++) begin
            chk("b2b_dout", {7'd0, dout1}, 8'd1);
            chk("b2b_dv", {7'd0, dv1}, 8'd1);
            chk("b2b_last", {7'd0, dl1}, (k == 7) ? 8'd1 : 8'd0);
            step();
        end
        chk("b2b_end_dv", {7'd0, dv1}, 8'd0);

        // Multi-lane 0xB4 on 8x2: MSB-first then LSB-first back-to-back.
        s_valid2 = 1'b1;
        s_data2  = 8'hB4;
        s_lsb2   = 1'b0;
        step();
        s_valid2 = 1'b0;
        #1;
        exp_lanes = 8'b10_11_01_00;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                s_valid2 = 1'b1;
                s_lsb2   = 1'b1;
                #1;
            end
            chk("ml_msb_dout", {6'd0, dout2}, {6'd0, exp_lanes[7-2*k -: 2]});
            chk("ml_msb_last", {7'd0, dl2}, (k == 3) ? 8'd1 : 8'd0);
            step();
        end
        s_valid2 = 1'b0;
        s_lsb2   = 1'b0;
        #1;
        exp_lanes = 8'b00_01_11_10;
        for (int k = 0; k < 4; k++) begin
            chk("ml_lsb_dout", {6'd0, dout2}, {6'd0, exp_lanes[7-2*k -: 2]});
            chk("ml_lsb_dv", {7'd0, dv2}, 8'd1);
            chk("ml_lsb_last", {7'd0, dl2}, (k == 3) ? 8'd1 : 8'd0);
            step();
        end
        chk("ml_end_dv", {7'd0, dv2}, 8'd0);
        chk("ml_end_dout", {6'd0, dout2}, 8'd0);

        // Backpressure: stall 3 cycles at beat 3 of 0x1E MSB-first.
        s_valid1 = 1'b1;
        s_data1  = 8'h1E;
        s_lsb1   = 1'b0;
        step();
        s_valid1 = 1'b0;
        #1;
        exp_word = 8'b0001_1110;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                dready1  = 1'b0;
                s_valid1 = 1'b1;
                s_data1  = 8'h55;
                #1;
                for (int i = 0; i < 3; i++) begin
                    chk("bp_hold_dout", {7'd0, dout1}, 8'd1);
                    chk("bp_hold_last", {7'd0, dl1}, 8'd0);
                    chk("bp_sready", {7'd0, s_ready1}, 8'd0);
                    step();
                end
                s_valid1 = 1'b0;
                dready1  = 1'b1;
                #1;
            end
            chk("bp_dout", {7'd0, dout1}, {7'd0, exp_word[7-k]});
            chk("bp_last", {7'd0, dl1}, (k == 7) ? 8'd1 : 8'd0);
            step();
        end
        chk("bp_end_dv", {7'd0, dv1}, 8'd0);

        // Reset mid-word during beat 4 of 0xA5.
        s_valid1 = 1'b1;
        s_data1  = 8'hA5;
        s_lsb1   = 1'b0;
        step();
        s_valid1 = 1'b0;
        repeat (4) step();
        chk("mid_beat4", {7'd0, dout1}, 8'd0);
        chk("mid_beat4_dv", {7'd0, dv1}, 8'd1);
        reset = 1'b1;
        #1;
        chk("mr_dout", {7'd0, dout1}, 8'd0);
        chk("mr_dv", {7'd0, dv1}, 8'd0);
        chk("mr_last", {7'd0, dl1}, 8'd0);
        chk("mr_busy", {7'd0, busy1}, 8'd0);
        step();
        reset = 1'b0;
        #1;
        chk("mr_ready", {7'd0, s_ready1}, 8'd1);
        s_valid1 = 1'b1;
        s_data1  = 8'h1E;
        s_lsb1   = 1'b0;
        step();
        s_valid1 = 1'b0;
        #1;
        exp_word = 8'b0001_1110;
        for (int k = 0; k < 8; k++) begin
            chk("mr_seq_dout", {7'd0, dout1}, {7'd0, exp_word[7-k]});
            chk("mr_seq_last", {7'd0, dl1}, (k == 7) ? 8'd1 : 8'd0);
            step();
        end
        chk("mr_end_dv", {7'd0, dv1}, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
